// File: rtl/led_fx_pkg.sv
// Shared definitions for the LED effect engine: command word layout and modes.
package led_fx_pkg;

  localparam int LED_W    = 10;
  localparam int CMD_W    = 14;
  localparam int PAT_LSB  = 0;
  localparam int MODE_LSB = 10;
  localparam int RATE_LSB = 12;

  typedef enum logic [1:0] {
    FX_STATIC = 2'd0,
    FX_BLINK  = 2'd1,
    FX_CHASE  = 2'd2,
    FX_DIM    = 2'd3
  } fx_mode_e;

  // Mask of tick-counter bits that must all be set for a step.
  // Rate 3 steps on every base tick, rate 0 on every eighth.
  function automatic logic [2:0] rate_mask(input logic [1:0] rate);
    case (rate)
      2'd0:    return 3'b111;
      2'd1:    return 3'b011;
      2'd2:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/led_fx_tick_gen.sv
// Base-tick prescaler plus 3-bit tick counter; emits a registered, rate-masked
// one-cycle step pulse. A restart clears the timebase and swallows any step.
module led_fx_tick_gen
  import led_fx_pkg::*;
#(
  parameter int BASE_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic [1:0] rate,
  output logic       step
);

  localparam int PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    tcnt_q, tcnt_d;
  logic          step_q, step_d;
  logic          base_tick;
  logic [2:0]    mask;

  // Next-state for prescaler, tick counter and step pulse.
  always_comb begin
    mask      = rate_mask(rate);
    base_tick = (presc_q == PW'(BASE_DIV - 1));
    presc_d   = presc_q + PW'(1);
    tcnt_d    = tcnt_q;
    step_d    = 1'b0;
    if (restart) begin
      presc_d = '0;
      tcnt_d  = '0;
    end else if (base_tick) begin
      presc_d = '0;
      tcnt_d  = tcnt_q + 3'd1;
      step_d  = ((tcnt_q & mask) == mask);
    end
  end

  // Timebase state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tcnt_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      step_q  <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/led_fx_engine.sv
// LED effect engine: latches the PIO command word, restarts the effect on any
// change, and drives the LEDs with static / blink / chase / PWM-dim patterns.
// Effect state advances on the cycle after a step pulse; leds is registered
// from the effect state, so a new command shows on leds two edges after it
// appears on led_cmd.
module led_fx_engine
  import led_fx_pkg::*;
#(
  parameter int BASE_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] led_cmd,
  output logic [9:0]  leds,
  output logic        step
);

  logic [CMD_W-1:0] cmd_q;
  logic             restart;
  logic [LED_W-1:0] pattern;
  fx_mode_e         mode;
  logic [1:0]       rate;
  logic             step_w;

  logic             phase_q, phase_d;
  logic [LED_W-1:0] rot_q, rot_d;
  logic [1:0]       pwm_q, pwm_d;
  logic [LED_W-1:0] leds_q, leds_d;

  assign restart = (led_cmd != cmd_q);
  assign pattern = cmd_q[PAT_LSB +: LED_W];
  assign mode    = fx_mode_e'(cmd_q[MODE_LSB +: 2]);
  assign rate    = cmd_q[RATE_LSB +: 2];

  led_fx_tick_gen #(.BASE_DIV(BASE_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .rate    (rate),
    .step    (step_w)
  );

  // Effect state next-state: restart reloads, otherwise step advances the
  // active mode only.
  always_comb begin
    phase_d = phase_q;
    rot_d   = rot_q;
    pwm_d   = pwm_q + 2'd1;
    if (restart) begin
      phase_d = 1'b1;
      rot_d   = led_cmd[PAT_LSB +: LED_W];
    end else if (step_w) begin
      if (mode == FX_BLINK) phase_d = ~phase_q;
      if (mode == FX_CHASE) rot_d   = {rot_q[LED_W-2:0], rot_q[LED_W-1]};
    end
  end

  // Output mux for the current mode.
  always_comb begin
    leds_d = pattern;
    case (mode)
      FX_STATIC: leds_d = pattern;
      FX_BLINK:  leds_d = phase_q ? pattern : '0;
      FX_CHASE:  leds_d = rot_q;
      FX_DIM:    leds_d = (pwm_q <= rate) ? pattern : '0;
    endcase
  end

  // Command, effect and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q   <= '0;
      phase_q <= 1'b1;
      rot_q   <= '0;
      pwm_q   <= '0;
      leds_q  <= '0;
    end else begin
      cmd_q   <= led_cmd;
      phase_q <= phase_d;
      rot_q   <= rot_d;
      pwm_q   <= pwm_d;
      leds_q  <= leds_d;
    end
  end

  assign leds = leds_q;
  assign step = step_w;

endmodule

// File: tb/tb_led_fx_engine.sv
// Directed bench for led_fx_engine with BASE_DIV = 4. Time t counts rising
// edges since the restart edge; all sampling happens on falling edges.
module tb_led_fx_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] led_cmd = 14'h0;
  logic [9:0]  leds;
  logic        step;

  int n_chk  = 0;
  int n_fail = 0;
  int t      = 0;

  led_fx_engine #(.BASE_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .led_cmd (led_cmd),
    .leds    (leds),
    .step    (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    t++;
  endtask

  task automatic goto_t(input int tt);
    while (t < tt) cyc();
  endtask

  // Called on a falling edge; the next rising edge is the restart edge (t=0).
  task automatic set_cmd(input logic [13:0] v);
    led_cmd = v;
    @(negedge clk);
    t = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt, first, on;

    // Reset and static, rate 0
    led_cmd = 14'h0155;
    repeat (3) @(negedge clk);
    chk("rst_leds", leds, 10'h000);
    chk("rst_step", {9'd0, step}, 10'd0);
    reset_n = 1'b1;
    @(negedge clk);
    t = 0;
    chk("static_t0", leds, 10'h000);
    cyc();
    chk("static_t1", leds, 10'h155);
    cnt = 0; first = 0;
    while (t < 64) begin
      cyc();
      if (step) begin
        cnt++;
        if (first == 0) first = t;
      end
    end
    chk("static_step_cnt", 10'(cnt), 10'd2);
    chk("static_step_first", 10'(first), 10'd32);
    chk("static_step_t64", {9'd0, step}, 10'd1);
    chk("static_hold", leds, 10'h155);

    // Blink, rate 3
    set_cmd(14'h3555);
    goto_t(4);  chk("blink_step4", {9'd0, step}, 10'd1);
    goto_t(5);  chk("blink_t5", leds, 10'h155);
    cyc();      chk("blink_t6", leds, 10'h000);
    goto_t(8);  chk("blink_step8", {9'd0, step}, 10'd1);
    goto_t(9);  chk("blink_t9", leds, 10'h000);
    cyc();      chk("blink_t10", leds, 10'h155);
    goto_t(13); chk("blink_t13", leds, 10'h155);
    cyc();      chk("blink_t14", leds, 10'h000);

    // Dim rate 1: 2 of 4
    set_cmd(14'h1FFF);
    goto_t(2);
    on = 0;
    repeat (8) begin
      cyc();
      if (leds == 10'h3FF) on++;
      else chk("dim1_off_val", leds, 10'h000);
    end
    chk("dim1_duty", 10'(on), 10'd4);

    // Dim rate 0 (rate-only change restarts): 1 of 4, step at 32
    set_cmd(14'h0FFF);
    on = 0; cnt = 0; first = 0;
    while (t < 32) begin
      cyc();
      if (step) begin
        cnt++;
        if (first == 0) first = t;
      end
      if (t >= 3 && t <= 10 && leds == 10'h3FF) on++;
    end
    chk("dim0_duty", 10'(on), 10'd2);
    chk("rate_restart_cnt", 10'(cnt), 10'd1);
    chk("rate_restart_first", 10'(first), 10'd32);

    // Dim rate 3: always on
    set_cmd(14'h3FFF);
    goto_t(2);
    on = 0;
    repeat (8) begin
      cyc();
      if (leds == 10'h3FF) on++;
    end
    chk("dim3_duty", 10'(on), 10'd8);

    // Chase with wrap, rate 3, pattern 0x201
    set_cmd(14'h3A01);
    cyc();      chk("chase_t1", leds, 10'h201);
    goto_t(5);  chk("chase_t5", leds, 10'h201);
    cyc();      chk("chase_wrap", leds, 10'h003);
    goto_t(10); chk("chase_t10", leds, 10'h006);
    goto_t(14); chk("chase_t14", leds, 10'h00C);

    // Restart collision: step would rise at t=16
    goto_t(15);
    set_cmd(14'h38F0);
    chk("coll_no_step", {9'd0, step}, 10'd0);
    cyc();
    chk("coll_reload", leds, 10'h0F0);
    chk("coll_t1_step", {9'd0, step}, 10'd0);
    goto_t(3);  chk("coll_t3_step", {9'd0, step}, 10'd0);
    cyc();      chk("coll_next_step", {9'd0, step}, 10'd1);

    // Mid-effect reset while step is high
    reset_n = 1'b0;
    #1;
    chk("midrst_leds", leds, 10'h000);
    chk("midrst_step", {9'd0, step}, 10'd0);
    repeat (2) @(negedge clk);
    chk("midrst_hold", leds, 10'h000);
    reset_n = 1'b1;
    @(negedge clk);
    t = 0;
    cyc();      chk("postrst_t1", leds, 10'h0F0);
    goto_t(4);  chk("postrst_step", {9'd0, step}, 10'd1);
    goto_t(6);  chk("postrst_rot", leds, 10'h1E0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_fx_engine.md
# led_fx_engine

Downstream consumer of the 14-bit LED PIO word written by the Nios II software. It decodes that word as a pattern/mode/rate command and drives the 10 board LEDs with one of four effects: static, blink, rotating chase, or PWM dimming. Software writes the PIO once and the effect then runs without further CPU writes. The block sits between the PIO `out_port` and the `LEDR[9:0]` top-level pins.

## Interface
Parameters:
- `BASE_DIV`, default 12_500_000: clocks per base tick. At 50 MHz this gives 4 Hz. Benches use 4.

Ports:
- `clk`  in  1  system clock, 50 MHz, same domain as the PIO.
- `reset_n`  in  1  reset: asynchronous, active-low.
- `led_cmd`  in  14  PIO word. `[9:0]` pattern, `[11:10]` mode, `[13:12]` rate.
- `leds`  out  10  registered LED drive.
- `step`  out  1  one-cycle pulse on every effect step, for debug and verification.

## Operation
- Command register `cmd_q` (14 bits) samples `led_cmd` every clock.
- **Restart condition:** `led_cmd != cmd_q`. On the edge where `cmd_q` takes the new value:
  - prescaler clears to 0;
  - tick counter clears to 0;
  - `phase` sets to 1;
  - rotate register `rot` loads `led_cmd[9:0]`;
  - `step` is suppressed in that cycle.
- **Tick generator:**
  - `presc` counts 0..BASE_DIV-1 and wraps; `base_tick` is asserted when `presc == BASE_DIV-1`.
  - 3-bit `tcnt` increments on each `base_tick` and wraps 7 to 0.
  - `step` fires on a `base_tick` when `(tcnt & M) == M`, where M = (1 << (3-rate)) - 1.
  - Resulting step period: BASE_DIV × 2^(3-rate) clocks. Rate 3 is fastest (BASE_DIV); rate 0 is slowest (8×BASE_DIV).
- **Modes** (`cmd_q[11:10]`):
  - 00 STATIC: `leds = pattern`; `step` still pulses.
  - 01 BLINK: `phase` toggles on each step; `leds = phase ? pattern : 0`.
  - 10 CHASE: `rot` rotates left by 1 on each step (bit9 wraps to bit0); `leds = rot`.
  - 11 DIM: 2-bit `pwm` counter is free-running, +1 every clock. `leds = (pwm <= rate) ? pattern : 0`, giving duty (rate+1)/4. Rate 3 is continuously on. `pwm` is not cleared on restart.
- `rot` and `phase` update only in their own modes. Each restart reloads both.
- CHASE with pattern 0x000 stays 0x000; with 0x3FF it stays 0x3FF.

## Timing
- Reset values:
  - `leds` = 0, `step` = 0, `cmd_q` = 0;
  - `presc` = 0, `tcnt` = 0, `pwm` = 0;
  - `phase` = 1, `rot` = 0.
- Reset asserted mid-effect returns all state to the reset values immediately. After release, a nonzero `led_cmd` is treated as a change and triggers a restart.
- **Latency:** `led_cmd` changes before edge N. `cmd_q` updates at N and `leds` reflects the new command at N+1, i.e. 2 edges.
- First step after a restart occurs BASE_DIV × 2^(3-rate) clocks after the restart edge.
- Restart coincident with a would-be step: restart wins and no step occurs.
- Changing only the rate or mode field still counts as a restart.
- `step` is registered and high for exactly one clock.

## Structure
- Package `led_fx_pkg`:
  - `LED_W = 10`;
  - field positions: `PAT_LSB = 0`, `MODE_LSB = 10`, `RATE_LSB = 12`;
  - mode enum `FX_STATIC`, `FX_BLINK`, `FX_CHASE`, `FX_DIM`.
- Sub-module `led_fx_tick_gen` holds `presc`, `tcnt` and the rate-masked step. Its inputs are `clk`, `reset_n`, `restart` and `rate`; its output is `step`.
- The top level holds `cmd_q`, change detect, `phase`, `rot`, `pwm` and the output mux.

## Test plan
All scenarios use BASE_DIV = 4.
- **Reset and static:** hold reset, then release with `led_cmd = 0x0155` (static, rate 0) → `leds = 0x000` during reset; `leds = 0x155` 2 edges after release; `step` pulses every 32 clocks.
- **Blink:** `led_cmd = 0x3555` (blink, rate 3) → `leds = 0x155` for 4 clocks, then 0x000 for 4 clocks, alternating; `step` pulses every 4 clocks.
- **Chase wrap:** `led_cmd = 0x3A01` (chase, rate 3, pattern 0x201) → successive steps give 0x003, 0x006, 0x00C, …; bit9 wraps to bit0.
- **Dim duty:** `led_cmd = 0x1FFF`, then 0x0FFF, then 0x3FFF (dim, pattern 0x3FF, rates 1, 0, 3) → `leds` on 2 of every 4 clocks, then 1 of 4, then continuously.
- **Restart collision:** rewrite the command on the cycle a step is due → no `step` pulse; the next step comes a full period after the restart edge; `rot` is reloaded with the new pattern.
- **Mid-effect reset:** assert `reset_n` low during a chase → `leds = 0` and `step = 0` immediately; after release the chase restarts from the loaded pattern.
